// File: rtl/exe_stage_alu.sv
// Execute stage: ARM condition evaluation against the owned NZCV register,
// ALU operation, and the EX/MEM pipeline register with gated enables.
module exe_stage_alu #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_ADDR_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic                  stall,
  input  logic                  flush,
  input  logic [3:0]            exe_cmd,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic                  wb_enable,
  input  logic                  status_write_enable,
  input  logic [3:0]            cond,
  input  logic [DATA_W-1:0]     val_rn,
  input  logic [DATA_W-1:0]     val2,
  input  logic [DATA_W-1:0]     val_rm,
  input  logic [REG_ADDR_W-1:0] dest,
  output logic                  out_valid,
  output logic [DATA_W-1:0]     alu_result,
  output logic                  out_mem_read,
  output logic                  out_mem_write,
  output logic                  out_wb_enable,
  output logic [REG_ADDR_W-1:0] out_dest,
  output logic [DATA_W-1:0]     out_store_data,
  output logic [3:0]            status,
  output logic                  cond_pass
);

  logic [3:0]            status_q, status_d;
  logic                  valid_q, valid_d;
  logic [DATA_W-1:0]     result_q, result_d;
  logic                  mem_read_q, mem_read_d;
  logic                  mem_write_q, mem_write_d;
  logic                  wb_enable_q, wb_enable_d;
  logic [REG_ADDR_W-1:0] dest_q, dest_d;
  logic [DATA_W-1:0]     store_q, store_d;

  logic                  flag_n, flag_z, flag_c, flag_v;
  logic                  fire;
  logic [DATA_W:0]       sum;
  logic [DATA_W-1:0]     res;
  logic                  is_arith, is_logic, is_sub, ovf;
  logic [3:0]            flags_new;

  assign {flag_n, flag_z, flag_c, flag_v} = status_q;

  always_comb begin
    cond_pass = 1'b0;
    case (cond)
      4'b0000: cond_pass = flag_z;
      4'b0001: cond_pass = !flag_z;
      4'b0010: cond_pass = flag_c;
      4'b0011: cond_pass = !flag_c;
      4'b0100: cond_pass = flag_n;
      4'b0101: cond_pass = !flag_n;
      4'b0110: cond_pass = flag_v;
      4'b0111: cond_pass = !flag_v;
      4'b1000: cond_pass = flag_c && !flag_z;
      4'b1001: cond_pass = !flag_c || flag_z;
      4'b1010: cond_pass = (flag_n == flag_v);
      4'b1011: cond_pass = (flag_n != flag_v);
      4'b1100: cond_pass = !flag_z && (flag_n == flag_v);
      4'b1101: cond_pass = flag_z || (flag_n != flag_v);
      4'b1110: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  assign fire = in_valid && cond_pass && !stall && !flush;

  // Subtract forms add ~val2 plus carry-in so the carry-out is ARM's NOT-borrow.
  always_comb begin
    sum      = '0;
    res      = '0;
    is_arith = 1'b0;
    is_logic = 1'b0;
    is_sub   = 1'b0;
    case (exe_cmd)
      4'b0001: begin res = val2;          is_logic = 1'b1; end
      4'b1001: begin res = ~val2;         is_logic = 1'b1; end
      4'b0110: begin res = val_rn & val2; is_logic = 1'b1; end
      4'b0111: begin res = val_rn | val2; is_logic = 1'b1; end
      4'b1000: begin res = val_rn ^ val2; is_logic = 1'b1; end
      4'b0010: begin
        sum      = {1'b0, val_rn} + {1'b0, val2};
        is_arith = 1'b1;
      end
      4'b0011: begin
        sum      = {1'b0, val_rn} + {1'b0, val2} + {{DATA_W{1'b0}}, flag_c};
        is_arith = 1'b1;
      end
      4'b0100: begin
        sum      = {1'b0, val_rn} + {1'b0, ~val2} + {{DATA_W{1'b0}}, 1'b1};
        is_arith = 1'b1;
        is_sub   = 1'b1;
      end
      4'b0101: begin
        sum      = {1'b0, val_rn} + {1'b0, ~val2} + {{DATA_W{1'b0}}, flag_c};
        is_arith = 1'b1;
        is_sub   = 1'b1;
      end
      default: res = '0;
    endcase
    if (is_arith) res = sum[DATA_W-1:0];

    if (is_sub) ovf = (val_rn[DATA_W-1] != val2[DATA_W-1]) && (res[DATA_W-1] != val_rn[DATA_W-1]);
    else        ovf = (val_rn[DATA_W-1] == val2[DATA_W-1]) && (res[DATA_W-1] != val_rn[DATA_W-1]);

    if (is_arith)      flags_new = {res[DATA_W-1], (res == '0), sum[DATA_W], ovf};
    else if (is_logic) flags_new = {res[DATA_W-1], (res == '0), flag_c, flag_v};
    else               flags_new = status_q;

    status_d = (fire && status_write_enable) ? flags_new : status_q;
  end

  always_comb begin
    valid_d     = valid_q;
    result_d    = result_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    wb_enable_d = wb_enable_q;
    dest_d      = dest_q;
    store_d     = store_q;
    if (!stall) begin
      if (flush) begin
        valid_d     = 1'b0;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        wb_enable_d = 1'b0;
      end else begin
        valid_d     = in_valid;
        mem_read_d  = mem_read && fire;
        mem_write_d = mem_write && fire;
        wb_enable_d = wb_enable && fire;
        result_d    = res;
        dest_d      = dest;
        store_d     = val_rm;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      status_q    <= '0;
      valid_q     <= 1'b0;
      result_q    <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      wb_enable_q <= 1'b0;
      dest_q      <= '0;
      store_q     <= '0;
    end else begin
      status_q    <= status_d;
      valid_q     <= valid_d;
      result_q    <= result_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      wb_enable_q <= wb_enable_d;
      dest_q      <= dest_d;
      store_q     <= store_d;
    end
  end

  assign status         = status_q;
  assign out_valid      = valid_q;
  assign alu_result     = result_q;
  assign out_mem_read   = mem_read_q;
  assign out_mem_write  = mem_write_q;
  assign out_wb_enable  = wb_enable_q;
  assign out_dest       = dest_q;
  assign out_store_data = store_q;

endmodule

// File: tb/tb_exe_stage_alu.sv
// Bench for exe_stage_alu: directed scenarios plus randomized traffic,
// checked against a wide-integer arithmetic reference model.
module tb_exe_stage_alu;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, stall, flush;
  logic [3:0]  exe_cmd;
  logic        mem_read, mem_write, wb_enable, status_write_enable;
  logic [3:0]  cond;
  logic [31:0] val_rn, val2, val_rm;
  logic [3:0]  dest;
  logic        out_valid;
  logic [31:0] alu_result;
  logic        out_mem_read, out_mem_write, out_wb_enable;
  logic [3:0]  out_dest;
  logic [31:0] out_store_data;
  logic [3:0]  status;
  logic        cond_pass;

  int errors = 0;
  int checks = 0;

  // reference model state
  logic [3:0]  m_status;
  logic        m_valid, m_mr, m_mw, m_wb;
  logic [31:0] m_res, m_sd;
  logic [3:0]  m_dest;

  localparam longint MAX_S = 64'sh7FFFFFFF;
  localparam longint MIN_S = -64'sh80000000;

  exe_stage_alu #(.DATA_W(32), .REG_ADDR_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .stall(stall), .flush(flush),
    .exe_cmd(exe_cmd), .mem_read(mem_read), .mem_write(mem_write),
    .wb_enable(wb_enable), .status_write_enable(status_write_enable),
    .cond(cond), .val_rn(val_rn), .val2(val2), .val_rm(val_rm), .dest(dest),
    .out_valid(out_valid), .alu_result(alu_result), .out_mem_read(out_mem_read),
    .out_mem_write(out_mem_write), .out_wb_enable(out_wb_enable),
    .out_dest(out_dest), .out_store_data(out_store_data), .status(status),
    .cond_pass(cond_pass)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic model_cond(input logic [3:0] c, input logic [3:0] st);
    logic n, z, cy, v;
    {n, z, cy, v} = st;
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cy;
      4'd3:  return !cy;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cy && !z;
      4'd9:  return !cy || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Flags from exact signed/unsigned integer results rather than bit tricks.
  function automatic void model_alu(input logic [3:0] cmd, input logic [31:0] rn, input logic [31:0] v2,
                                    input logic [3:0] st, output logic [31:0] res, output logic [3:0] nf);
    logic n, z, cy, v, cin;
    int ia, ib;
    longint sr;
    logic [63:0] u;
    {n, z, cy, v} = st;
    ia = rn;
    ib = v2;
    nf = st;
    res = '0;
    case (cmd)
      4'd1: res = v2;
      4'd9: res = ~v2;
      4'd6: res = rn & v2;
      4'd7: res = rn | v2;
      4'd8: res = rn ^ v2;
      4'd2, 4'd3: begin
        cin = (cmd == 4'd3) ? cy : 1'b0;
        u   = 64'(rn) + 64'(v2) + 64'(cin);
        res = rn + v2 + 32'(cin);
        cy  = (u > 64'hFFFF_FFFF);
        sr  = longint'(ia) + longint'(ib) + longint'(cin);
        v   = (sr > MAX_S) || (sr < MIN_S);
      end
      4'd4, 4'd5: begin
        cin = (cmd == 4'd5) ? !cy : 1'b0;
        res = rn - v2 - 32'(cin);
        cy  = (64'(rn) >= 64'(v2) + 64'(cin));
        sr  = longint'(ia) - longint'(ib) - longint'(cin);
        v   = (sr > MAX_S) || (sr < MIN_S);
      end
      default: return;
    endcase
    nf = {res[31], res == 32'd0, cy, v};
  endfunction

  task automatic check_outputs(input string tag);
    check({tag, "_valid"}, 32'(out_valid), 32'(m_valid));
    check({tag, "_res"}, alu_result, m_res);
    check({tag, "_mr"}, 32'(out_mem_read), 32'(m_mr));
    check({tag, "_mw"}, 32'(out_mem_write), 32'(m_mw));
    check({tag, "_wb"}, 32'(out_wb_enable), 32'(m_wb));
    check({tag, "_dest"}, 32'(out_dest), 32'(m_dest));
    check({tag, "_sd"}, out_store_data, m_sd);
    check({tag, "_status"}, 32'(status), 32'(m_status));
  endtask

  task automatic model_reset();
    m_status = '0; m_valid = 0; m_mr = 0; m_mw = 0; m_wb = 0;
    m_res = '0; m_sd = '0; m_dest = '0;
  endtask

  // Called at posedge+1; applies inputs, checks cond_pass, clocks, checks EX/MEM.
  task automatic exec(input string tag, input logic iv, input logic st, input logic fl,
                      input logic [3:0] cmd, input logic mr, input logic mw, input logic wb,
                      input logic swe, input logic [3:0] cd, input logic [31:0] rn,
                      input logic [31:0] v2, input logic [31:0] rm, input logic [3:0] dst);
    logic cp, fire;
    logic [31:0] res;
    logic [3:0] nf;
    in_valid = iv; stall = st; flush = fl; exe_cmd = cmd; mem_read = mr;
    mem_write = mw; wb_enable = wb; status_write_enable = swe; cond = cd;
    val_rn = rn; val2 = v2; val_rm = rm; dest = dst;
    #1;
    cp = model_cond(cd, m_status);
    check({tag, "_cp"}, 32'(cond_pass), 32'(cp));
    fire = iv && cp && !st && !fl;
    model_alu(cmd, rn, v2, m_status, res, nf);
    @(posedge clk);
    #1;
    if (!st) begin
      if (fl) begin
        m_valid = 0; m_mr = 0; m_mw = 0; m_wb = 0;
      end else begin
        m_valid = iv; m_mr = mr && fire; m_mw = mw && fire; m_wb = wb && fire;
        m_res = res; m_dest = dst; m_sd = rm;
      end
    end
    if (fire && swe) m_status = nf;
    check_outputs(tag);
  endtask

  initial begin
    rst = 0; in_valid = 0; stall = 0; flush = 0; exe_cmd = 0; mem_read = 0;
    mem_write = 0; wb_enable = 0; status_write_enable = 0; cond = 0;
    val_rn = 0; val2 = 0; val_rm = 0; dest = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset");
    #2 rst = 1;
    @(posedge clk);
    #1;
    check_outputs("idle");

    // directed scenarios: tag, iv st fl cmd mr mw wb swe cond rn v2 rm dest
    exec("adds", 1,0,0, 4'd2, 0,0,1,1, 4'hE, 32'hFFFF_FFFF, 32'd1, 32'h11, 4'd1);
    check("tp_adds_res", alu_result, 32'd0);
    check("tp_adds_status", 32'(status), 32'h6);
    check("tp_adds_wb", 32'(out_wb_enable), 32'd1);
    exec("subs", 1,0,0, 4'd4, 0,0,1,1, 4'hE, 32'd5, 32'd7, 32'h0, 4'd2);
    check("tp_subs_res", alu_result, 32'hFFFF_FFFE);
    check("tp_subs_status", 32'(status), 32'h8);
    exec("addne", 1,0,0, 4'd2, 0,0,1,0, 4'h1, 32'd1, 32'd1, 32'h0, 4'd3);
    check("tp_addne_res", alu_result, 32'd2);
    exec("cmp", 1,0,0, 4'd4, 0,0,0,1, 4'hE, 32'd3, 32'd3, 32'h0, 4'd0);
    exec("addeq", 1,0,0, 4'd2, 0,0,1,0, 4'h0, 32'd4, 32'd4, 32'h0, 4'd5);
    check("tp_addeq_wb", 32'(out_wb_enable), 32'd1);
    exec("addne2", 1,0,0, 4'd2, 0,0,1,0, 4'h1, 32'd4, 32'd4, 32'h0, 4'd6);
    check("tp_addne_nop_valid", 32'(out_valid), 32'd1);
    check("tp_addne_nop_wb", 32'(out_wb_enable), 32'd0);
    exec("adds_ovf", 1,0,0, 4'd2, 0,0,1,1, 4'hE, 32'h7FFF_FFFF, 32'd1, 32'h0, 4'd7);
    check("tp_ovf_status", 32'(status), 32'h9);
    exec("ands", 1,0,0, 4'd6, 0,0,1,1, 4'hE, 32'hF0, 32'h0F, 32'h0, 4'd8);
    check("tp_ands_res", alu_result, 32'd0);
    check("tp_ands_status", 32'(status), 32'h5);
    exec("cmp_c1", 1,0,0, 4'd4, 0,0,0,1, 4'hE, 32'd3, 32'd3, 32'h0, 4'd0);
    exec("sbc_c1", 1,0,0, 4'd5, 0,0,1,0, 4'hE, 32'd10, 32'd3, 32'h0, 4'd9);
    check("tp_sbc_c1", alu_result, 32'd7);
    exec("subs_c0", 1,0,0, 4'd4, 0,0,0,1, 4'hE, 32'd5, 32'd7, 32'h0, 4'd0);
    exec("sbc_c0", 1,0,0, 4'd5, 0,0,1,0, 4'hE, 32'd10, 32'd3, 32'h0, 4'd9);
    check("tp_sbc_c0", alu_result, 32'd6);
    exec("cmp_c1b", 1,0,0, 4'd4, 0,0,0,1, 4'hE, 32'd3, 32'd3, 32'h0, 4'd0);
    exec("adc_c1", 1,0,0, 4'd3, 0,0,1,0, 4'hE, 32'd1, 32'd1, 32'h0, 4'd10);
    check("tp_adc_c1", alu_result, 32'd3);

    // STR under a 3-cycle stall, then a flushed STR, then reset during a stall
    exec("str", 1,0,0, 4'd2, 0,1,0,0, 4'hE, 32'h100, 32'h4, 32'hCAFE, 4'd2);
    for (int i = 0; i < 3; i++)
      exec("str_stall", 1,1,0, 4'd4, 0,1,0,1, 4'hE, 32'h200, 32'h8, 32'hBEEF, 4'd3);
    exec("str_flush", 1,0,1, 4'd4, 0,1,0,1, 4'hE, 32'h5, 32'h7, 32'h1234, 4'd4);
    check("tp_flush_valid", 32'(out_valid), 32'd0);
    check("tp_flush_mw", 32'(out_mem_write), 32'd0);
    exec("pre_rst", 1,0,0, 4'd2, 1,0,1,1, 4'hE, 32'h8000_0000, 32'h8000_0000, 32'h77, 4'd11);
    stall = 1; flush = 1;
    #2 rst = 0;
    #1;
    model_reset();
    check_outputs("rst_mid_stall");
    #1 rst = 1;
    @(posedge clk);
    #1;
    check_outputs("post_rst");

    for (int i = 0; i < 400; i++) begin
      logic [3:0] cd;
      logic [31:0] rn, v2;
      cd = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'hE;
      rn = ($urandom_range(0, 3) == 0) ? 32'h7FFF_FFFF + 32'($urandom_range(0, 2)) : $urandom;
      v2 = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      exec("rand", ($urandom_range(0, 7) != 0), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 7) == 0), 4'($urandom_range(0, 15)),
           1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), cd,
           rn, v2, $urandom, 4'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/exe_stage_alu.md
Name: exe_stage_alu

Overview:
- Consumer end of the control-unit decode interface: execute stage that takes the decoded exe_cmd, enables, condition field and operands from the ID/EX boundary.
- Evaluates the ARM condition against its own NZCV status register and performs the ALU operation.
- Registers the result and the surviving memory/writeback enables into the EX/MEM pipeline register.
- Owns the architectural status register; supports stall, flush and back-to-back flag dependencies.

Parameters:
DATA_W, 32, operand/result width
REG_ADDR_W, 4, destination register index width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
in_valid  in  1  instruction present at stage input
stall  in  1  hold all state (EX/MEM register and status)
flush  in  1  kill incoming instruction, insert bubble
exe_cmd  in  4  ALU command: MOV 0001, MVN 1001, ADD/LDR/STR 0010, ADC 0011, SUB/CMP 0100, SBC 0101, AND/TST 0110, ORR 0111, EOR 1000
mem_read  in  1  load
mem_write  in  1  store
wb_enable  in  1  register writeback
status_write_enable  in  1  update NZCV
cond  in  4  ARM condition field
val_rn  in  DATA_W  first operand
val2  in  DATA_W  second operand (shifted/immediate, already resolved)
val_rm  in  DATA_W  store data
dest  in  REG_ADDR_W  destination register
out_valid  out  1  EX/MEM entry valid
alu_result  out  DATA_W  registered result / memory address
out_mem_read, out_mem_write, out_wb_enable  out  1 each  registered gated enables
out_dest  out  REG_ADDR_W  registered destination
out_store_data  out  DATA_W  registered val_rm
status  out  4  NZCV register {N,Z,C,V}
cond_pass  out  1  combinational: cond true against current status

Behaviour:
- Reset (rst=0, async): status=0000; out_valid=0; all out_* enables=0; alu_result, out_dest, out_store_data=0.
- Condition: EQ0000 Z; NE0001 !Z; CS0010 C; CC0011 !C; MI0100 N; PL0101 !N; VS0110 V; VC0111 !V; HI1000 C&!Z; LS1001 !C|Z; GE1010 N==V; LT1011 N!=V; GT1100 !Z&(N==V); LE1101 Z|(N!=V); AL1110 1; 1111 never.
- fire = in_valid & cond_pass & !stall & !flush.
- Arithmetic uses DATA_W+1-bit sum. C is the carry-out. C for SUB/SBC is NOT borrow.
  - ADD: rn+v2. ADC: rn+v2+C. SUB: rn-v2. SBC: rn-v2-!C.
  - V for add forms: sign(rn)==sign(v2) and sign(res)!=sign(rn).
  - V for sub forms: sign(rn)!=sign(v2) and sign(res)!=sign(rn).
- Logical ops and MOV: AND, ORR, EOR; MOV=v2; MVN=~v2. These update N,Z only; C,V keep their old values.
- Unlisted exe_cmd: result 0, flags unchanged.
- N=res[MSB]; Z=(res==0).
- Status register written at the clock edge iff fire & status_write_enable.
  - The next instruction's cond_pass sees the new flags with zero bubbles.
  - ADC/SBC use the C value from before the edge.
- EX/MEM register at the edge:
  - stall=1: hold everything. Flush is ignored while stalled. in_valid is ignored.
  - flush=1, stall=0: out_valid=0; all enables=0; data regs don't-care (hold).
  - Otherwise: out_valid=in_valid. Enables = input enable & fire. Data regs load alu_result/dest/val_rm.
  - cond-failed instruction: out_valid=1, all enables 0 (visible no-op).
- Latency: 1 cycle input->EX/MEM outputs. Throughput: 1 instruction per cycle.
- Reset asserted mid-stall or mid-flush: reset wins immediately.

Test Plan:
- Reset, release; ADDS rn=FFFFFFFF v2=1 cond=1110 -> next cycle alu_result=0, status=0110 (Z,C), out_wb_enable=1.
- SUBS rn=5 v2=7 -> alu_result=FFFFFFFE, status=1000. Next cycle ADDNE rn=1 v2=1 -> executes, result 2.
- CMP rn=3 v2=3 (status_write_enable=1, wb=0) followed by ADDEQ, then ADDNE in consecutive cycles -> ADDEQ out_wb_enable=1. ADDNE out_valid=1, out_wb_enable=0.
- ADDS 7FFFFFFF+1 -> status=1001 (N,V). ANDS rn=F0 v2=0F -> result 0, status=0101 (Z set, N clear, V kept).
- With C=1, SBC rn=10 v2=3 -> 7. With C=0 -> 6. ADC with C=1, rn=1 v2=1 -> 3.
- STR with stall held 3 cycles -> EX/MEM and status frozen. Flush asserted with stall=0 -> out_valid=0, out_mem_write=0, status unchanged. rst pulsed low mid-stall -> all outputs 0 immediately.
